sseg_scan_driver: RTL

Parametrised, time-multiplexed seven-segment display driver with its own refresh timer and digit scan counter. It replaces the hand-wired timer + counter + single-digit decoder arrangement in the display tops. It takes a packed vector of hex nibbles, a decimal-point vector, a per-digit enable mask and an optional leading-zero blanking mode. It produces registered active-low SSEG/AN/DP for the Nexys-class board display, with tear-free frame-synchronous updates.

---
 rtl/sseg_pkg.sv | 30 +++
 rtl/hex_to_sseg.sv | 11 +
 rtl/sseg_scan_driver.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low hex
// segment table (bit order g..a), the blank pattern and the default
// per-digit refresh period.
package sseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // 1 ms per digit slot at 100 MHz
    localparam int REFRESH_COUNT_1MS = 99_999;

    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h40, // 0
        7'h79, // 1
        7'h24, // 2
        7'h30, // 3
        7'h19, // 4
        7'h12, // 5
        7'h02, // 6
        7'h78, // 7
        7'h00, // 8
        7'h10, // 9
        7'h08, // A
        7'h03, // b
        7'h46, // C
        7'h21, // d
        7'h06, // E
        7'h0E  // F
    };

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational nibble-to-segment lookup (active-low, g..a).
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed seven-segment driver. A refresh counter divides each
// digit slot, a digit index scans the display, and all rendering comes from
// shadow registers that are reloaded only at a frame boundary so a frame is
// never drawn from a mix of old and new inputs.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int N_DIGITS      = 8,
    parameter int REFRESH_COUNT = REFRESH_COUNT_1MS,
    parameter int CNT_W         = 17
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   data,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    lz_blank,
    input  logic                    update,
    output logic [6:0]              SSEG,
    output logic [N_DIGITS-1:0]     AN,
    output logic                    DP,
    output logic                    frame_done
);

    localparam int                IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_COUNT);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]       refresh_cnt;
    logic [IDX_W-1:0]       digit_idx;
    logic                   tick;
    logic                   pending;

    logic [4*N_DIGITS-1:0]  shadow_data;
    logic [N_DIGITS-1:0]    shadow_dp;
    logic [N_DIGITS-1:0]    shadow_en;
    logic                   shadow_lz;

    logic [N_DIGITS-1:0]    digit_on;
    logic                   zero_run;

    logic [3:0]             sel_nibble;
    logic [6:0]             sel_seg;
    logic                   sel_on;
    logic                   sel_dp;

    // tick marks the final cycle of a digit slot; frame_done is the tick of the last slot
    assign tick       = (refresh_cnt == CNT_LAST);
    assign frame_done = tick && (digit_idx == IDX_LAST);

    // Refresh counter and digit scan index
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (tick) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Pending request and frame-boundary capture into the shadow registers;
    // an update on the boundary cycle itself is folded into that capture
    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= 1'b0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            shadow_en   <= '0;
            shadow_lz   <= 1'b0;
        end else if (frame_done) begin
            if (pending || update) begin
                shadow_data <= data;
                shadow_dp   <= dp_in;
                shadow_en   <= digit_en;
                shadow_lz   <= lz_blank;
            end
            pending <= 1'b0;
        end else if (update) begin
            pending <= 1'b1;
        end
    end

    // Leading-zero suppression: walk from the leftmost digit while every digit seen is a bare zero
    always_comb begin
        zero_run = 1'b1;
        digit_on = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (shadow_data[4*i +: 4] == 4'h0) && !shadow_dp[i];
            digit_on[i] = shadow_en[i] && !(shadow_lz && (i > 0) && zero_run);
        end
    end

    assign sel_nibble = shadow_data[{digit_idx, 2'b00} +: 4];
    assign sel_on     = digit_on[digit_idx];
    assign sel_dp     = shadow_dp[digit_idx];

    hex_to_sseg u_hex_to_sseg (
        .nibble (sel_nibble),
        .seg    (sel_seg)
    );

    // Registered active-low outputs; anodes are released on the slot's last cycle to avoid ghosting
    always_ff @(posedge clk) begin
        if (reset) begin
            SSEG <= SEG_BLANK;
            AN   <= '1;
            DP   <= 1'b1;
        end else begin
            if (sel_on) begin
                SSEG <= sel_seg;
                DP   <= ~sel_dp;
            end else begin
                SSEG <= SEG_BLANK;
                DP   <= 1'b1;
            end
            if (sel_on && !tick) begin
                AN <= ~(N_DIGITS'(1) << digit_idx);
            end else begin
                AN <= '1;
            end
        end
    end

endmodule
